mem_ctrl_multi: RTL and testbench
=================================

MEM_CTRL_MULTI -- requirements
Module: mem_ctrl_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of request channels (2..4).
REQ-002 SHALL have parameter IO_HI, default 2'b11, value of addr[17:16] marking I/O space.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rdy  input  1  global enable; low freezes the block.
REQ-006 SHALL have port ch_req  input  NUM_CH  per-channel request, held high until ch_done.
REQ-007 SHALL have port ch_wr  input  NUM_CH  per-channel direction, 1 = write.
REQ-008 SHALL have port ch_addr  input  32*NUM_CH  per-channel byte address; channel i occupies bits [32i+31:32i].
REQ-009 SHALL have port ch_wdata  input  32*NUM_CH  per-channel write data, little-endian.
REQ-010 SHALL have port ch_size  input  2*NUM_CH  per-channel size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is treated as 4 bytes.
REQ-011 SHALL have port flush  input  1  rollback strobe.
REQ-012 SHALL have port flush_mask  input  NUM_CH  channels affected by flush.
REQ-013 SHALL have port ch_done  output  NUM_CH  one-hot, single-cycle completion pulse.
REQ-014 SHALL have port rdata  output  32  read result, zero-extended, valid while ch_done is high.
REQ-015 SHALL have port mem_din  input  8  RAM read byte, returned one cycle after its address.
REQ-016 SHALL have port mem_dout  output  8  RAM write byte.
REQ-017 SHALL have port mem_a  output  32  RAM byte address.
REQ-018 SHALL have port mem_wr  output  1  1 = write this cycle.
REQ-019 SHALL have port io_buffer_full  input  1  UART buffer full.

Function
REQ-020 SHALL implement the states IDLE, IO_WAIT, XFER and LAST.
REQ-021 In IDLE with any eligible ch_req, SHALL grant round-robin: search starts at (last_grant+1) mod NUM_CH; the granted address, data, size and direction are latched at grant.
REQ-022 After grant, SHALL go to IO_WAIT if the request is a write and addr[17:16]==IO_HI; otherwise it SHALL go to XFER.
REQ-023 SHALL stay in IO_WAIT while io_buffer_full=1 and drive mem_wr=0; when io_buffer_full=0 it SHALL go to XFER.
REQ-024 In XFER, SHALL drive mem_a = base+k for byte k = 0..n-1 with one byte per cycle (n = 1, 2 or 4).
REQ-025 Write in XFER: SHALL drive mem_wr=1 and mem_dout = wdata[8k+7:8k]; after byte n-1 it SHALL return to IDLE and pulse ch_done for the granted channel in that same cycle.
REQ-026 Read in XFER: SHALL keep mem_wr=0 and capture mem_din into byte k-1 in the cycle that issues byte k; after issuing byte n-1 it SHALL enter LAST.
REQ-027 In LAST, SHALL capture byte n-1, pulse ch_done, present rdata, and return to IDLE; read latency is n+1 enabled cycles after the grant cycle.
REQ-028 SHALL drive mem_a=0, mem_wr=0 and mem_dout=0 in IDLE and in IO_WAIT.
REQ-029 SHALL NOT grant a request in the cycle it pulses ch_done; the minimum gap between transfers is one IDLE cycle.
REQ-030 When flush=1 and the active transfer is a read on a channel set in flush_mask, SHALL return to IDLE next cycle with no ch_done.
REQ-031 Writes SHALL never be aborted by flush.
REQ-032 In a flush cycle, SHALL NOT grant channels set in flush_mask.
REQ-033 When rdy=0, SHALL freeze all state, freeze the capture register and the round-robin pointer, hold mem_a, force mem_wr=0, and suppress ch_done.
REQ-034 Because mem_a is held while rdy=0, the pending capture SHALL remain valid on resume.
REQ-035 Address increments SHALL wrap modulo 2^32.
REQ-036 ch_req falling before ch_done SHALL NOT affect a transfer that is already granted.

Reset
REQ-037 On rst=1, SHALL immediately go to IDLE and set ch_done=0, rdata=0, mem_a=0, mem_wr=0, mem_dout=0, and last_grant=NUM_CH-1, so that channel 0 wins first.
REQ-038 Reset asserted mid-transfer SHALL abandon the transfer; no ch_done SHALL follow after rst is released.

Verification
REQ-039 Read, ch0, 4 bytes at 0x100, RAM holds 11 22 33 44 -> mem_a 0x100..0x103 on consecutive cycles, ch_done[0] 5 cycles after grant, rdata=0x44332211.
REQ-040 Simultaneous ch0 and ch1 reads, back to back, from reset -> grant order ch0, ch1, ch0; each transfer is separated by one IDLE cycle.
REQ-041 Write, 1 byte 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then one cycle with mem_wr=1, mem_a=0x30000, mem_dout=0x41, and ch_done in that cycle.
REQ-042 Read of 4 bytes on ch1, flush with flush_mask=2'b10 after byte 1 -> IDLE next cycle, no ch_done[1]; the same flush during a 4-byte write -> all 4 bytes written and ch_done asserted.
REQ-043 2-byte read of A5 5A at 0x200 with rdy low for 2 cycles after byte 0 -> mem_a holds 0x200, no spurious mem_wr, rdata=0x00005AA5.
REQ-044 rst pulsed during byte 2 of a write -> all outputs are 0 within the reset cycle, and no ch_done follows.

Source files
------------

// File: rtl/mem_ctrl_multi.sv
// mem_ctrl_multi
// Multi-channel byte-serial memory controller. Up to four requesters share one
// byte-wide RAM port. Requests are granted round-robin, then moved one byte per
// cycle (little-endian) at base+k. Writes into the I/O window wait for the UART
// buffer to drain before the first byte goes out.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   rdy               global enable; low freezes every register and masks strobes
//   ch_req/ch_wr      per-channel request (held until ch_done) and direction
//   ch_addr/ch_wdata  per-channel byte address and write data, 32 bits per channel
//   ch_size           per-channel size code (0:1, 1:2, 2/3:4 bytes)
//   flush/flush_mask  rollback strobe and the channels it applies to
//   ch_done           one-hot completion pulse
//   rdata             zero-extended read result, valid with ch_done
//   mem_a/mem_wr/mem_dout/mem_din  byte-wide RAM port (read data one cycle late)
//   io_buffer_full    UART buffer full; stalls I/O-space writes

module mem_ctrl_multi #(
    parameter int         NUM_CH = 2,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NUM_CH-1:0]     ch_req,
    input  logic [NUM_CH-1:0]     ch_wr,
    input  logic [32*NUM_CH-1:0]  ch_addr,
    input  logic [32*NUM_CH-1:0]  ch_wdata,
    input  logic [2*NUM_CH-1:0]   ch_size,
    input  logic                  flush,
    input  logic [NUM_CH-1:0]     flush_mask,
    output logic [NUM_CH-1:0]     ch_done,
    output logic [31:0]           rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [31:0]           mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    localparam int GW = $clog2(NUM_CH);
    // One extra bit so last_grant+1+i can be range-reduced with a single subtract.
    localparam int CW = GW + 1;

    typedef enum logic [1:0] {
        IDLE,
        IO_WAIT,
        XFER,
        LAST
    } state_t;

    state_t state, state_next;

    logic [GW-1:0] last_grant;
    logic [GW-1:0] cur_ch;
    logic          cur_wr;
    logic [31:0]   base;
    logic [31:0]   cur_wdata;
    logic [1:0]    last_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   cap;

    logic [NUM_CH-1:0] eligible;
    logic              grant_found;
    logic [GW-1:0]     grant_idx;
    logic [CW-1:0]     cand;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [1:0]        sel_size;
    logic              sel_wr;
    logic [1:0]        sel_last;
    logic              flush_hit;

    // Round-robin arbiter: the first eligible channel after the last winner.
    // Channels being flushed this cycle are not eligible.
    always_comb begin
        eligible    = ch_req & ~(flush ? flush_mask : '0);
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, last_grant} + CW'(i + 1);
            if (cand >= CW'(NUM_CH)) begin
                cand = cand - CW'(NUM_CH);
            end
            if (!grant_found && eligible[cand[GW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[GW-1:0];
            end
        end
    end

    assign sel_addr  = ch_addr[{grant_idx, 5'b00000} +: 32];
    assign sel_wdata = ch_wdata[{grant_idx, 5'b00000} +: 32];
    assign sel_size  = ch_size[{grant_idx, 1'b0} +: 2];
    assign sel_wr    = ch_wr[grant_idx];

    // Size code 3 is treated as a full word.
    always_comb begin
        case (sel_size)
            2'd0:    sel_last = 2'd0;
            2'd1:    sel_last = 2'd1;
            default: sel_last = 2'd3;
        endcase
    end

    // Only reads can be rolled back; a write always runs to completion.
    assign flush_hit = flush && flush_mask[cur_ch] && !cur_wr;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_next;
        end
    end

    // Next state and RAM-side outputs. mem_a is decoded from frozen state, so it
    // holds while rdy is low; the strobes are gated by rdy instead.
    always_comb begin
        state_next = state;
        mem_a      = '0;
        mem_wr     = 1'b0;
        mem_dout   = '0;
        ch_done    = '0;
        rdata      = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    if (sel_wr && (sel_addr[17:16] == IO_HI)) begin
                        state_next = IO_WAIT;
                    end else begin
                        state_next = XFER;
                    end
                end
            end
            IO_WAIT: begin
                if (!io_buffer_full) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                mem_a    = base + {30'b0, byte_idx};
                mem_wr   = cur_wr & rdy;
                mem_dout = cur_wr ? cur_wdata[{byte_idx, 3'b000} +: 8] : 8'h00;
                if (flush_hit) begin
                    state_next = IDLE;
                end else if (byte_idx == last_idx) begin
                    if (cur_wr) begin
                        state_next       = IDLE;
                        ch_done[cur_ch]  = rdy;
                    end else begin
                        state_next = LAST;
                    end
                end
            end
            LAST: begin
                // The final byte arrives on mem_din this cycle and is merged in
                // directly so rdata is valid alongside ch_done.
                rdata      = cap | ({24'b0, mem_din} << {last_idx, 3'b000});
                state_next = IDLE;
                if (!flush_hit) begin
                    ch_done[cur_ch] = rdy;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transfer context latched at grant, byte counter and read capture register.
    // The capture register is cleared at grant so unused upper bytes read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GW'(NUM_CH - 1);
            cur_ch     <= '0;
            cur_wr     <= 1'b0;
            base       <= '0;
            cur_wdata  <= '0;
            last_idx   <= '0;
            byte_idx   <= '0;
            cap        <= '0;
        end else if (rdy) begin
            if (state == IDLE && grant_found) begin
                last_grant <= grant_idx;
                cur_ch     <= grant_idx;
                cur_wr     <= sel_wr;
                base       <= sel_addr;
                cur_wdata  <= sel_wdata;
                last_idx   <= sel_last;
                byte_idx   <= 2'd0;
                cap        <= '0;
            end else if (state == XFER) begin
                // mem_din now carries the byte addressed in the previous cycle.
                if (!cur_wr && byte_idx != 2'd0) begin
                    cap[{byte_idx - 2'd1, 3'b000} +: 8] <= mem_din;
                end
                if (byte_idx != last_idx) begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl_multi.sv
// tb_mem_ctrl_multi
// Directed scenarios for mem_ctrl_multi with a queue-based scoreboard. The
// stimulus pushes expected completions and expected RAM writes; a monitor
// forked beside it pops and compares whenever ch_done or mem_wr is seen.

module tb_mem_ctrl_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [1:0]  ch_req;
    logic [1:0]  ch_wr;
    logic [63:0] ch_addr;
    logic [63:0] ch_wdata;
    logic [3:0]  ch_size;
    logic        flush;
    logic [1:0]  flush_mask;
    logic [1:0]  ch_done;
    logic [31:0] rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  done;
        logic        is_rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    mem_ctrl_multi #(
        .NUM_CH (2),
        .IO_HI  (2'b11)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .ch_req         (ch_req),
        .ch_wr          (ch_wr),
        .ch_addr        (ch_addr),
        .ch_wdata       (ch_wdata),
        .ch_size        (ch_size),
        .flush          (flush),
        .flush_mask     (flush_mask),
        .ch_done        (ch_done),
        .rdata          (rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk = ~clk;

    // Fixed RAM image: a few hand-placed bytes, everything else a simple pattern.
    function automatic logic [7:0] ramByte(input logic [31:0] a);
        case (a)
            32'h0000_0100: ramByte = 8'h11;
            32'h0000_0101: ramByte = 8'h22;
            32'h0000_0102: ramByte = 8'h33;
            32'h0000_0103: ramByte = 8'h44;
            32'h0000_0200: ramByte = 8'hA5;
            32'h0000_0201: ramByte = 8'h5A;
            default:       ramByte = a[7:0] + 8'h37;
        endcase
    endfunction

    // Synchronous RAM read port, enabled by the same global rdy.
    always @(posedge clk) begin
        if (rdy) begin
            mem_din <= ramByte(mem_a);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size);
        ch_wr[ch]              = wr;
        ch_addr[32*ch +: 32]   = addr;
        ch_wdata[32*ch +: 32]  = wdata;
        ch_size[2*ch +: 2]     = size;
        ch_req[ch]             = 1'b1;
    endtask

    task automatic expectRead(input int ch, input logic [31:0] data);
        exp_t e;
        e.done  = 2'(1 << ch);
        e.is_rd = 1'b1;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    task automatic expectWrite(input int ch, input logic [31:0] addr,
                               input logic [31:0] data, input int n);
        exp_t e;
        wr_t  w;
        e.done  = 2'(1 << ch);
        e.is_rd = 1'b0;
        e.data  = '0;
        exp_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            w.addr = addr + 32'(k);
            w.data = data[8*k +: 8];
            wr_q.push_back(w);
        end
    endtask

    task automatic pushWriteByte(input logic [31:0] addr, input logic [7:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        wr_q.push_back(w);
    endtask

    // Scoreboard monitor: compares every completion and every RAM write.
    task automatic monitor();
        exp_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (ch_done != 2'b00) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_done: ch_done=%b, expected no completion", ch_done);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("done_channel", {30'b0, ch_done}, {30'b0, e.done});
                    if (e.is_rd) begin
                        checkOutput("read_data", rdata, e.data);
                    end
                end
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_write: mem_a=0x%08h mem_dout=0x%02h, expected no write", mem_a, mem_dout);
                end else begin
                    w = wr_q.pop_front();
                    checkOutput("write_addr", mem_a, w.addr);
                    checkOutput("write_data", {24'b0, mem_dout}, {24'b0, w.data});
                end
            end
        end
    endtask

    task automatic waitDone(input int max_cyc, output int cyc);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (ch_done != 2'b00) break;
            if (cyc >= max_cyc) begin
                total++;
                bad++;
                $display("[TB] FAIL done_timeout: no ch_done after %0d cycles, expected one", cyc);
                break;
            end
        end
    endtask

    initial begin
        int          cyc;
        logic [31:0] s2_next [3];
        s2_next = '{32'h0000_0200, 32'h0000_0100, 32'h0000_0000};

        rst            = 1'b1;
        rdy            = 1'b1;
        ch_req         = '0;
        ch_wr          = '0;
        ch_addr        = '0;
        ch_wdata       = '0;
        ch_size        = '0;
        flush          = 1'b0;
        flush_mask     = '0;
        io_buffer_full = 1'b0;

        fork
            monitor();
            begin
                #100000;
                $display("[TB] FAIL watchdog: time limit reached before the end of the run");
                $fatal(1, "[TB] watchdog expired");
            end
        join_none

        // Reset values.
        repeat (2) @(negedge clk);
        checkOutput("rst_ch_done", {30'b0, ch_done}, 32'h0);
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_mem_a", mem_a, 32'h0);
        checkOutput("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
        checkOutput("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 4-byte read on ch0 at 0x100.
        $display("[TB] 4-byte read ch0");
        expectRead(0, 32'h4433_2211);
        applyStimulus(0, 1'b0, 32'h0000_0100, 32'h0, 2'd2);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("s1_addr%0d", c - 1), mem_a, 32'h0000_0100 + 32'(c - 1));
        end
        @(negedge clk);
        checkOutput("s1_done_latency", {30'b0, ch_done}, 32'h1);
        ch_req[0] = 1'b0;
        @(negedge clk);

        // Both channels requesting continuously from reset: ch0, ch1, ch0.
        $display("[TB] round-robin ch0/ch1");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expectRead(0, 32'h0000_0011);
        expectRead(1, 32'h0000_5AA5);
        expectRead(0, 32'h0000_0011);
        applyStimulus(0, 1'b0, 32'h0000_0100, 32'h0, 2'd0);
        applyStimulus(1, 1'b0, 32'h0000_0200, 32'h0, 2'd1);
        for (int t = 0; t < 3; t++) begin
            waitDone(8, cyc);
            if (t == 2) ch_req = 2'b00;
            @(negedge clk);
            checkOutput($sformatf("s2_idle_gap%0d", t), mem_a, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("s2_next_addr%0d", t), mem_a, s2_next[t]);
        end

        // I/O-space write held off by a full UART buffer.
        $display("[TB] I/O write with buffer full");
        expectWrite(0, 32'h0003_0000, 32'h0000_0041, 1);
        io_buffer_full = 1'b1;
        applyStimulus(0, 1'b1, 32'h0003_0000, 32'h0000_0041, 2'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("s3_iowait_wr%0d", c), {31'b0, mem_wr}, 32'h0);
            if (c == 3) io_buffer_full = 1'b0;
        end
        @(negedge clk);
        checkOutput("s3_mem_wr", {31'b0, mem_wr}, 32'h1);
        checkOutput("s3_mem_a", mem_a, 32'h0003_0000);
        checkOutput("s3_mem_dout", {24'b0, mem_dout}, 32'h41);
        checkOutput("s3_done", {30'b0, ch_done}, 32'h1);
        ch_req[0] = 1'b0;
        @(negedge clk);

        // Flush aborts a read on ch1 after byte 1; flushed channel not regranted.
        $display("[TB] flush during read");
        applyStimulus(1, 1'b0, 32'h0000_0300, 32'h0, 2'd2);
        repeat (2) @(negedge clk);
        flush      = 1'b1;
        flush_mask = 2'b10;
        @(negedge clk);
        checkOutput("s4_flush_idle", mem_a, 32'h0);
        checkOutput("s4_flush_no_done", {30'b0, ch_done}, 32'h0);
        @(negedge clk);
        checkOutput("s4_flush_no_grant", mem_a, 32'h0);
        flush      = 1'b0;
        flush_mask = 2'b00;
        ch_req[1]  = 1'b0;
        @(negedge clk);

        // Same flush during a 4-byte write has no effect.
        $display("[TB] flush during write");
        expectWrite(1, 32'h0000_0400, 32'hDDCC_BBAA, 4);
        applyStimulus(1, 1'b1, 32'h0000_0400, 32'hDDCC_BBAA, 2'd2);
        repeat (2) @(negedge clk);
        flush      = 1'b1;
        flush_mask = 2'b10;
        @(negedge clk);
        flush      = 1'b0;
        flush_mask = 2'b00;
        @(negedge clk);
        checkOutput("s4_write_done", {30'b0, ch_done}, 32'h2);
        ch_req[1] = 1'b0;
        @(negedge clk);

        // 2-byte read with rdy low for two cycles on byte 0.
        $display("[TB] rdy stall during read");
        expectRead(0, 32'h0000_5AA5);
        applyStimulus(0, 1'b0, 32'h0000_0200, 32'h0, 2'd1);
        @(negedge clk);
        checkOutput("s5_byte0_addr", mem_a, 32'h0000_0200);
        rdy = 1'b0;
        @(negedge clk);
        checkOutput("s5_hold_addr1", mem_a, 32'h0000_0200);
        checkOutput("s5_hold_wr", {31'b0, mem_wr}, 32'h0);
        @(negedge clk);
        checkOutput("s5_hold_addr2", mem_a, 32'h0000_0200);
        rdy = 1'b1;
        waitDone(6, cyc);
        checkOutput("s5_resume_latency", 32'(cyc), 32'd2);
        ch_req[0] = 1'b0;
        @(negedge clk);

        // Reset during byte 2 of a 4-byte write.
        $display("[TB] reset mid-write");
        pushWriteByte(32'h0000_0500, 8'h11);
        pushWriteByte(32'h0000_0501, 8'h22);
        applyStimulus(0, 1'b1, 32'h0000_0500, 32'h4433_2211, 2'd2);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("s6_rst_mem_a", mem_a, 32'h0);
        checkOutput("s6_rst_mem_wr", {31'b0, mem_wr}, 32'h0);
        checkOutput("s6_rst_mem_dout", {24'b0, mem_dout}, 32'h0);
        checkOutput("s6_rst_done", {30'b0, ch_done}, 32'h0);
        checkOutput("s6_rst_rdata", rdata, 32'h0);
        ch_req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Address wrap at 2^32, request dropped after grant.
        $display("[TB] address wrap and early request drop");
        expectRead(1, 32'h0000_3736);
        applyStimulus(1, 1'b0, 32'hFFFF_FFFF, 32'h0, 2'd1);
        @(negedge clk);
        checkOutput("s7_addr_top", mem_a, 32'hFFFF_FFFF);
        ch_req[1] = 1'b0;
        @(negedge clk);
        checkOutput("s7_addr_wrap", mem_a, 32'h0);
        waitDone(4, cyc);
        checkOutput("s7_done_latency", 32'(cyc), 32'd1);

        repeat (3) @(negedge clk);
        checkOutput("pending_done", 32'(exp_q.size()), 32'd0);
        checkOutput("pending_writes", 32'(wr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
